// File: rtl/dnn_eval_pkg.sv
// dnn_eval_pkg: shared constants, width helpers and case result type for the
// DNN output evaluator.
package dnn_eval_pkg;
   localparam int OUT_START = 2;
   typedef struct packed {
      logic correct;
      logic err;
   } case_result_t;
   function automatic int ci_w(int cpc);
      return cpc > 1 ? $clog2(cpc) : 1;
   endfunction
   function automatic int idx_w(int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int rc_w(int cl);
      return $clog2(cl + 1);
   endfunction
endpackage

// File: rtl/dnn_output_evaluator_if.sv
// dnn_output_evaluator_if: output-port observation inputs and scoreboard results.
interface dnn_output_evaluator_if
   import dnn_eval_pkg::*;
#(
   parameter int CPC = 18,
   parameter int NO = 1,
   parameter int CHECKLAST = 1000,
   parameter int CNT_W = 32
);
   logic [ci_w(CPC)-1:0]     cycle_index;
   logic [NO-1:0]            a_out;
   logic [NO-1:0]            y_out;
   logic                     tc_valid;
   logic                     tc_correct;
   logic [CNT_W-1:0]         total_error;
   logic [rc_w(CHECKLAST)-1:0] recent_correct;
   logic [CNT_W-1:0]         num_train;
   logic [CNT_W-1:0]         epoch;
   logic                     epoch_done;
   modport master (
      output cycle_index, a_out, y_out,
      input  tc_valid, tc_correct, total_error, recent_correct, num_train, epoch, epoch_done
   );
   modport slave (
      input  cycle_index, a_out, y_out,
      output tc_valid, tc_correct, total_error, recent_correct, num_train, epoch, epoch_done
   );
endinterface

// File: rtl/window_accuracy.sv
// window_accuracy: count of correct cases among the last CHECKLAST pushes,
// kept as a circular bit buffer with a running sum.
module window_accuracy
   import dnn_eval_pkg::*;
#(
   parameter int CHECKLAST = 1000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_bit,
   output logic [rc_w(CHECKLAST)-1:0] o_count
);
   localparam int PW = idx_w(CHECKLAST);
   localparam int RW = rc_w(CHECKLAST);
   logic [CHECKLAST-1:0] r_buf;
   logic [PW-1:0]        r_ptr;
   logic [RW-1:0]        r_count;
   // Unfilled slots hold 0, so the sum is exact before the first wrap.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_buf   <= '0;
         r_ptr   <= '0;
         r_count <= '0;
      end else if (i_push) begin
         r_buf[r_ptr] <= i_bit;
         r_ptr        <= r_ptr == PW'(CHECKLAST - 1) ? '0 : r_ptr + 1'b1;
         r_count      <= r_count - RW'(r_buf[r_ptr]) + RW'(i_bit);
      end
   assign o_count = r_count;
endmodule

// File: rtl/dnn_output_evaluator.sv
// dnn_output_evaluator: per-case correctness scoreboard for the DNN output port,
// tracking total errors, sliding-window accuracy, case and epoch counters.
module dnn_output_evaluator
   import dnn_eval_pkg::*;
#(
   parameter int CPC = 18,
   parameter int NO = 1,
   parameter int CHECKLAST = 1000,
   parameter int TRAINING_CASES = 10000,
   parameter int CNT_W = 32
) (
   input logic                   clk,
   input logic                   reset,
   dnn_output_evaluator_if.slave bus
);
   localparam int CW = ci_w(CPC);
   localparam int EW = idx_w(TRAINING_CASES);
   localparam int RW = rc_w(CHECKLAST);
   logic             w_mis, w_close, w_last;
   case_result_t     w_res;
   logic [RW-1:0]    w_recent;
   logic             r_err_acc, r_tc_valid, r_tc_correct, r_epoch_done;
   logic [CNT_W-1:0] r_total_error, r_num_train, r_epoch;
   logic [EW-1:0]    r_case_in_epoch;
   always_comb begin
      w_mis         = |(bus.a_out[NO-1:0] ^ bus.y_out[NO-1:0]);
      w_close       = bus.cycle_index == CW'(CPC - 1);
      w_last        = r_case_in_epoch == EW'(TRAINING_CASES - 1);
      w_res.err     = r_err_acc | w_mis;
      w_res.correct = ~w_res.err;
   end
   // Cycles before OUT_START carry stale pipeline data and never count.
   always_ff @(posedge clk or posedge reset)
      if (reset)
         r_err_acc <= 1'b0;
      else if (bus.cycle_index == CW'(OUT_START - 1))
         r_err_acc <= 1'b0;
      else if (bus.cycle_index >= CW'(OUT_START) && bus.cycle_index <= CW'(CPC - 2))
         r_err_acc <= r_err_acc | w_mis;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_tc_valid      <= 1'b0;
         r_tc_correct    <= 1'b0;
         r_epoch_done    <= 1'b0;
         r_total_error   <= '0;
         r_num_train     <= '0;
         r_epoch         <= '0;
         r_case_in_epoch <= '0;
      end else begin
         r_tc_valid   <= w_close;
         r_epoch_done <= w_close && w_last;
         if (w_close) begin
            r_tc_correct    <= w_res.correct;
            r_total_error   <= &r_total_error ? r_total_error : r_total_error + CNT_W'(w_res.err);
            r_num_train     <= r_num_train + 1'b1;
            r_case_in_epoch <= w_last ? '0 : r_case_in_epoch + 1'b1;
            r_epoch         <= r_epoch + CNT_W'(w_last);
         end
      end
   window_accuracy #(.CHECKLAST(CHECKLAST)) u_win (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_close),
      .i_bit   (w_res.correct),
      .o_count (w_recent)
   );
   assign bus.tc_valid       = r_tc_valid;
   assign bus.tc_correct     = r_tc_correct;
   assign bus.epoch_done     = r_epoch_done;
   assign bus.total_error    = r_total_error;
   assign bus.num_train      = r_num_train;
   assign bus.epoch          = r_epoch;
   assign bus.recent_correct = w_recent;
endmodule

// File: tb/tb_dnn_output_evaluator.sv
// tb_dnn_output_evaluator: directed and random block cycles on a wide-counter and
// a 2-bit-counter instance, checked against a case-level reference model.
module tb_dnn_output_evaluator;
   import dnn_eval_pkg::*;
   localparam int CPC = 6, NO = 1, CL = 4, TC = 3;
   localparam int CW = ci_w(CPC);
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dnn_output_evaluator_if #(.CPC(CPC), .NO(NO), .CHECKLAST(CL), .CNT_W(32)) ba ();
   dnn_output_evaluator_if #(.CPC(CPC), .NO(NO), .CHECKLAST(CL), .CNT_W(2))  bb ();
   dnn_output_evaluator #(.CPC(CPC), .NO(NO), .CHECKLAST(CL), .TRAINING_CASES(TC), .CNT_W(32))
      dut_a (.clk(clk), .reset(reset), .bus(ba.slave));
   dnn_output_evaluator #(.CPC(CPC), .NO(NO), .CHECKLAST(CL), .TRAINING_CASES(TC), .CNT_W(2))
      dut_b (.clk(clk), .reset(reset), .bus(bb.slave));

   int errors = 0, checks = 0;
   int m_tot, m_num, m_ep, m_cie;
   bit m_acc, m_tcv, m_tcc, m_epd;
   bit m_win[$];
   int dut_rc[$];
   int exp_rc[6] = '{1, 1, 2, 3, 3, 4};

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int rc = 0;
      foreach (m_win[i]) rc += int'(m_win[i]);
      chk("a.tc_valid", 64'(ba.tc_valid), 64'(m_tcv));
      chk("a.tc_correct", 64'(ba.tc_correct), 64'(m_tcc));
      chk("a.epoch_done", 64'(ba.epoch_done), 64'(m_epd));
      chk("a.total_error", 64'(ba.total_error), 64'(m_tot));
      chk("a.recent_correct", 64'(ba.recent_correct), 64'(rc));
      chk("a.num_train", 64'(ba.num_train), 64'(m_num));
      chk("a.epoch", 64'(ba.epoch), 64'(m_ep));
      chk("b.tc_valid", 64'(bb.tc_valid), 64'(m_tcv));
      chk("b.epoch_done", 64'(bb.epoch_done), 64'(m_epd));
      chk("b.total_error_sat", 64'(bb.total_error), 64'(m_tot > 3 ? 3 : m_tot));
      chk("b.num_train", 64'(bb.num_train), 64'(m_num % 4));
      chk("b.epoch", 64'(bb.epoch), 64'(m_ep % 4));
   endtask

   task automatic drive(int ci, logic [NO-1:0] a, logic [NO-1:0] y);
      ba.cycle_index = CW'(ci); ba.a_out = a; ba.y_out = y;
      bb.cycle_index = CW'(ci); bb.a_out = a; bb.y_out = y;
   endtask

   task automatic model_clear();
      m_tot = 0; m_num = 0; m_ep = 0; m_cie = 0;
      m_acc = 0; m_tcv = 0; m_tcc = 0; m_epd = 0;
      m_win.delete();
   endtask

   // Check what the previous edge produced, then present the next clock's inputs.
   task automatic step(int ci, logic [NO-1:0] a, logic [NO-1:0] y);
      bit err;
      @(negedge clk);
      check_all();
      if (ba.tc_valid === 1'b1) dut_rc.push_back(int'(ba.recent_correct));
      drive(ci, a, y);
      m_tcv = 0; m_epd = 0;
      if (ci == 1) m_acc = 0;
      else if (ci >= 2 && ci <= CPC - 2) m_acc = m_acc | (a != y);
      else if (ci == CPC - 1) begin
         err = m_acc | (a != y);
         m_tcv = 1; m_tcc = !err;
         m_tot += int'(err); m_num++;
         m_win.push_back(!err);
         if (m_win.size() > CL) void'(m_win.pop_front());
         if (m_cie == TC - 1) begin m_cie = 0; m_ep++; m_epd = 1; end
         else m_cie++;
      end
   endtask

   task automatic run_case(int bad);
      logic [NO-1:0] a;
      for (int ci = 0; ci < CPC; ci++) begin
         a = NO'($urandom);
         step(ci, a, ci == bad ? ~a : a);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, '0, '0);
      #1;
      model_clear();
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int bad;
      drive(0, '0, '0);
      model_clear();
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b0;
      run_case(-1);
      run_case(1);
      run_case(CPC - 1);
      do_reset();
      dut_rc.delete();
      run_case(-1); run_case(3); run_case(-1); run_case(-1); run_case(-1); run_case(-1);
      step(0, '0, '0);
      chk("window.closes", 64'(dut_rc.size()), 64'd6);
      for (int i = 0; i < 6 && i < dut_rc.size(); i++) chk("window.seq", 64'(dut_rc[i]), 64'(exp_rc[i]));
      do_reset();
      for (int i = 0; i < 7; i++) run_case(-1);
      for (int ci = 0; ci <= 3; ci++) step(ci, '0, ci == 2 ? 1'b1 : 1'b0);
      do_reset();
      run_case(-1);
      for (int i = 0; i < 5; i++) run_case(2);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 7) == 0) step(int'($urandom_range(CPC, 7)), NO'($urandom), NO'($urandom));
         bad = int'($urandom_range(0, 9));
         run_case(bad >= CPC ? -1 : bad);
      end
      step(0, '0, '0);
      step(0, '0, '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
